// File: rtl/inv_add_key_mix_cols.sv
// Decryption round back-half: AddRoundKey on accept, then InvMixColumns COLS_PER_CYCLE columns per cycle (bypassed on the final round).
// Latency 1 cycle (final round) or 1+4/COLS_PER_CYCLE; single state in flight, in_ready low until the result is taken.
module inv_add_key_mix_cols #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

  localparam logic [1:0] COL_STEP   = 2'(COLS_PER_CYCLE % 4);
  localparam logic [1:0] LAST_GROUP = 2'(4 - COLS_PER_CYCLE);

  fsm_t         fsm;
  logic [127:0] state_reg;
  logic [127:0] mixed;
  logic [1:0]   col;
  logic [31:0]  cur [4];
  logic [31:0]  mix_out [COLS_PER_CYCLE];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] a);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(a)));
    return x8 ^ a;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] a);
    logic [7:0] x2, x8;
    x2 = xtime(a);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ a;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] a);
    logic [7:0] x4, x8;
    x4 = xtime(xtime(a));
    x8 = xtime(x4);
    return x8 ^ x4 ^ a;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
            mule(a1) ^ mulb(a2) ^ muld(a3) ^ mul9(a0),
            mule(a2) ^ mulb(a3) ^ muld(a0) ^ mul9(a1),
            mule(a3) ^ mulb(a0) ^ muld(a1) ^ mul9(a2)};
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_cur
    assign cur[c] = state_reg[127-32*c -: 32];
  end

  // One mixer per lane; lane k always handles column col+k of the current group.
  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_mix
    assign mix_out[k] = inv_mix_col(cur[col + 2'(k)]);
  end

  for (genvar c = 0; c < 4; c++) begin : g_wb
    localparam logic [1:0] GROUP = 2'(c - c % COLS_PER_CYCLE);
    assign mixed[127-32*c -: 32] = (col == GROUP) ? mix_out[c % COLS_PER_CYCLE] : cur[c];
  end

  assign out_state = state_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm       <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      state_reg <= '0;
      col       <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            state_reg <= in_state ^ in_key;
            col       <= '0;
            in_ready  <= 1'b0;
            if (in_last) begin
              fsm       <= DONE;
              out_valid <= 1'b1;
            end else begin
              fsm <= BUSY;
            end
          end
        end
        BUSY: begin
          state_reg <= mixed;
          col       <= col + COL_STEP;
          if (col == LAST_GROUP) begin
            fsm       <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          fsm       <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
